// File: rtl/cpu_pkg.sv
// Shared definitions for micro_cpu_core: opcode and FSM state encodings plus
// instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_MUL = 4'hA,
    OP_DIV = 4'hB,
    OP_LDI = 4'hC,
    OP_JMP = 4'hD,
    OP_JZ  = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_OPND  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int DST_MSB = 3;
  localparam int DST_LSB = 2;
  localparam int SRC_MSB = 1;
  localparam int SRC_LSB = 0;

  // Instructions that carry a second (operand) word.
  function automatic logic two_word(input opcode_e op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for micro_cpu_core. Multiply/divide exist only when
// MICRO_CPU_MULDIV_EN is defined.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_MOV: result = b;
      OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~b;
      OP_SHL: begin
        result = {b[DATA_W-2:0], 1'b0};
        c      = b[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, b[DATA_W-1:1]};
        c      = b[0];
      end
`ifdef MICRO_CPU_MULDIV_EN
      OP_MUL: result = a * b;
      // Divide-by-zero saturates and flags through carry.
      OP_DIV: begin
        if (b == '0) begin
          result = '1;
          c      = 1'b1;
        end else begin
          result = a / b;
        end
      end
`endif
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/micro_cpu_core.sv
// Four-register micro CPU: FETCH -> (OPND) -> EXEC multi-cycle core with a
// req/ack instruction port. MICRO_CPU_MULDIV_EN enables MUL/DIV opcodes.
module micro_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              CLEARn,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ir,
  output logic              zf,
  output logic              cf,
  output logic              halted,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef MICRO_CPU_MULDIV_EN
  localparam opcode_e ALU_LAST = OP_DIV;
`else
  localparam opcode_e ALU_LAST = OP_SHR;
`endif

  state_e            state;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] opnd;
  opcode_e           op;
  logic [1:0]        dst;
  logic [1:0]        src;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_z;
  logic              alu_wr;
  logic              flag_wr;
  logic [ADDR_W-1:0] target;

  assign op      = opcode_e'(ir[OP_MSB:OP_LSB]);
  assign dst     = ir[DST_MSB:DST_LSB];
  assign src     = ir[SRC_MSB:SRC_LSB];
  assign alu_wr  = (op >= OP_MOV) && (op <= ALU_LAST);
  assign flag_wr = (op >= OP_ADD) && (op <= ALU_LAST);
  assign target  = ADDR_W'(opnd);

  // Request is gated by CLEARn so it drops the instant reset asserts.
  assign imem_req  = CLEARn && (((state == S_FETCH) && run) || (state == S_OPND));
  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_sel];

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (regs[dst]),
    .b      (regs[src]),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge clk) begin
    if ((state == S_OPND) && imem_ack) opnd <= imem_rdata;
  end

  always_ff @(posedge clk or negedge CLEARn) begin
    if (!CLEARn) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (run && imem_ack) begin
            ir    <= imem_rdata[7:0];
            pc    <= pc + 1'b1;
            state <= two_word(opcode_e'(imem_rdata[OP_MSB:OP_LSB])) ? S_OPND : S_EXEC;
          end
        end
        S_OPND: begin
          if (imem_ack) begin
            pc    <= pc + 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            OP_LDI: regs[dst] <= opnd;
            OP_JMP: pc <= target;
            OP_JZ:  if (zf) pc <= target;
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              if (alu_wr) regs[dst] <= alu_result;
              if (flag_wr) begin
                zf <= alu_z;
                cf <= alu_c;
              end
            end
          endcase
        end
        S_HALT: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_cpu_core.sv
// Self-checking bench for micro_cpu_core: directed programs plus random programs
// compared against an instruction-level reference model.
module tb_micro_cpu_core;

`ifdef MICRO_CPU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       CLEARn;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] pc;
  logic [7:0] ir;
  logic       zf;
  logic       cf;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  logic [7:0] mem [256];
  int wait_n = 0;
  int wcnt   = 0;
  int checks = 0;
  int failures = 0;

  int m_r [4];
  bit m_zf, m_cf, m_halt;
  int m_pc, m_cyc;

  always #5 clk = ~clk;

  micro_cpu_core #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .CLEARn     (CLEARn),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ir         (ir),
    .zf         (zf),
    .cf         (cf),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // Memory responder: acknowledges a request after wait_n idle cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (wcnt >= wait_n) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 8'($urandom);
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic peek(input int i, output logic [7:0] v);
    dbg_sel = 2'(i);
    #1;
    v = dbg_data;
  endtask

  task automatic launch(input int wn);
    wait_n = wn;
    run    = 1'b0;
    CLEARn = 1'b0;
    @(posedge clk); #2;
    CLEARn = 1'b1;
    @(posedge clk); #2;
    run = 1'b1;
  endtask

  task automatic wait_halt(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Instruction-level reference: executes mem from address 0 until HLT.
  task automatic model_run();
    int ins, op, d, s, a, b, res, opnd, c;
    bit alu;
    m_r = '{0, 0, 0, 0};
    m_zf = 0; m_cf = 0; m_halt = 0; m_pc = 0; m_cyc = 0;
    for (int step = 0; step < 2000; step++) begin
      if (m_halt) break;
      ins = int'(mem[m_pc]);
      m_pc = (m_pc + 1) % 256;
      m_cyc += wait_n + 2;
      op = ins / 16; d = (ins / 4) % 4; s = ins % 4;
      a = m_r[d]; b = m_r[s];
      opnd = 0;
      if (op >= 12 && op <= 14) begin
        opnd = int'(mem[m_pc]);
        m_pc = (m_pc + 1) % 256;
        m_cyc += wait_n + 1;
      end
      alu = 1; res = 0; c = 0;
      case (op)
        0: alu = 0;
        1: begin alu = 0; m_r[d] = b; end
        2: begin res = a + b; c = (res > 255) ? 1 : 0; end
        3: begin res = a - b + 256; c = (a < b) ? 1 : 0; end
        4: res = a & b;
        5: res = a | b;
        6: res = a ^ b;
        7: res = 255 - b;
        8: begin res = b * 2; c = (b >= 128) ? 1 : 0; end
        9: begin res = b / 2; c = b % 2; end
        10: if (MULDIV) res = a * b; else alu = 0;
        11: begin
          if (!MULDIV) alu = 0;
          else if (b == 0) begin res = 255; c = 1; end
          else res = a / b;
        end
        12: begin alu = 0; m_r[d] = opnd; end
        13: begin alu = 0; m_pc = opnd; end
        14: begin alu = 0; if (m_zf) m_pc = opnd; end
        default: begin alu = 0; m_halt = 1; end
      endcase
      if (alu) begin
        res = res % 256;
        m_r[d] = res;
        m_zf = (res == 0);
        m_cf = (c != 0);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    run = 1'b1; CLEARn = 1'b1; dbg_sel = 2'd0;
    #1 CLEARn = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if ({pc, ir} !== 16'h0000) begin failures++; $display("FAIL reset_pc_ir: got %h expected 0000", {pc, ir}); end
    checks++; if ({zf, cf, halted} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {zf, cf, halted}); end
    for (int i = 0; i < 4; i++) begin
      peek(i, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_r%0d: got %h expected 00", i, v); end
    end
    @(posedge clk); #2;
    run = 1'b0; CLEARn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b expected 0", imem_req); end
    end
    @(posedge clk); #2;
    run = 1'b1; #1;
    checks++; if ({imem_req, imem_addr} !== 9'h100) begin failures++; $display("FAIL first_req: got %h expected 100", {imem_req, imem_addr}); end
  endtask

  task automatic test_ldi_add();
    int cyc; bit ok; logic [7:0] v;
    clear_mem();
    mem[0] = 8'hC4; mem[1] = 8'h05; mem[2] = 8'hC8; mem[3] = 8'h03; mem[4] = 8'h26; mem[5] = 8'hF0;
    launch(0);
    wait_halt(cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL add_timeout: got no halt expected halt"); end
    checks++; if (cyc !== 10) begin failures++; $display("FAIL add_cycles: got %0d expected 10", cyc); end
    peek(1, v);
    checks++; if (v !== 8'h08) begin failures++; $display("FAIL add_r1: got %h expected 08", v); end
    checks++; if ({zf, cf} !== 2'b00) begin failures++; $display("FAIL add_flags: got %b expected 00", {zf, cf}); end
  endtask

  task automatic test_sub();
    int cyc; bit ok; logic [7:0] v;
    clear_mem();
    mem[0] = 8'hC4; mem[1] = 8'h03; mem[2] = 8'hC8; mem[3] = 8'h05; mem[4] = 8'h36; mem[5] = 8'hF0;
    launch(0);
    wait_halt(cyc, ok);
    peek(1, v);
    checks++; if (v !== 8'hFE) begin failures++; $display("FAIL sub_r1: got %h expected fe", v); end
    checks++; if ({zf, cf} !== 2'b01) begin failures++; $display("FAIL sub_flags: got %b expected 01", {zf, cf}); end
    clear_mem();
    mem[0] = 8'hCC; mem[1] = 8'h07; mem[2] = 8'h3F; mem[3] = 8'hF0;
    launch(0);
    wait_halt(cyc, ok);
    peek(3, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL subself_r3: got %h expected 00", v); end
    checks++; if ({zf, cf} !== 2'b10) begin failures++; $display("FAIL subself_flags: got %b expected 10", {zf, cf}); end
  endtask

  task automatic test_jz();
    int cyc; bit ok; logic [7:0] v;
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h00; mem[2] = 8'h30; mem[3] = 8'hE0; mem[4] = 8'h40;
    mem[8'h40] = 8'hC4; mem[8'h41] = 8'hAA;
    launch(0);
    wait_halt(cyc, ok);
    peek(1, v);
    checks++; if ({pc, v} !== 16'h43AA) begin failures++; $display("FAIL jz_taken: got pc/r1 %h expected 43aa", {pc, v}); end
    mem[1] = 8'h01; mem[2] = 8'h50;
    launch(0);
    wait_halt(cyc, ok);
    peek(1, v);
    checks++; if ({pc, v} !== 16'h0600) begin failures++; $display("FAIL jz_not_taken: got pc/r1 %h expected 0600", {pc, v}); end
  endtask

  task automatic test_wait_states();
    int cyc; bit ok;
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'hF0;
    launch(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({imem_req, imem_addr} !== 9'h100) begin failures++; $display("FAIL wait_stable%0d: got %h expected 100", i, {imem_req, imem_addr}); end
    end
    wait_halt(cyc, ok);
    model_run();
    checks++; if (cyc + 3 !== 10 || m_cyc !== 10) begin failures++; $display("FAIL wait_cycles: got %0d expected 10", cyc + 3); end
  endtask

  task automatic test_muldiv();
    int cyc; bit ok; logic [7:0] v;
    clear_mem();
    mem[0] = 8'hC4; mem[1] = 8'h10; mem[2] = 8'hC8; mem[3] = 8'h11;
    mem[4] = 8'hC0; mem[5] = 8'h00; mem[6] = 8'h20; mem[7] = 8'hA6;
    launch(0); model_run();
    wait_halt(cyc, ok);
    peek(1, v);
    checks++; if (v !== 8'h10) begin failures++; $display("FAIL mul_r1: got %h expected 10", v); end
    checks++; if ({zf, cf} !== (MULDIV ? 2'b00 : 2'b10)) begin failures++; $display("FAIL mul_flags: got %b expected %b", {zf, cf}, MULDIV ? 2'b00 : 2'b10); end
    checks++; if (cyc !== m_cyc) begin failures++; $display("FAIL mul_cycles: got %0d expected %0d", cyc, m_cyc); end
    clear_mem();
    mem[0] = 8'hCC; mem[1] = 8'h09; mem[2] = 8'hC0; mem[3] = 8'h00; mem[4] = 8'h20; mem[5] = 8'hBC;
    launch(0);
    wait_halt(cyc, ok);
    peek(3, v);
    checks++; if (v !== (MULDIV ? 8'hFF : 8'h09)) begin failures++; $display("FAIL div_r3: got %h expected %h", v, MULDIV ? 8'hFF : 8'h09); end
    checks++; if ({zf, cf} !== (MULDIV ? 2'b01 : 2'b10)) begin failures++; $display("FAIL div_flags: got %b expected %b", {zf, cf}, MULDIV ? 2'b01 : 2'b10); end
  endtask

  task automatic test_halt_wrap();
    int cyc; bit ok; logic [7:0] v;
    clear_mem();
    mem[0] = 8'hD0; mem[1] = 8'hFF; mem[8'hFF] = 8'hF0;
    launch(0);
    wait_halt(cyc, ok);
    checks++; if ({ok, pc} !== 9'h100) begin failures++; $display("FAIL halt_ff: got ok/pc %h expected 100", {ok, pc}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({halted, imem_req, pc} !== 10'h200) begin failures++; $display("FAIL halt_hold: got %h expected 200", {halted, imem_req, pc}); end
    end
    mem[8'hFF] = 8'hC4;
    launch(0);
    wait_halt(cyc, ok);
    peek(1, v);
    checks++; if ({pc, v} !== 16'h02D0) begin failures++; $display("FAIL wrap_operand: got pc/r1 %h expected 02d0", {pc, v}); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    clear_mem();
    mem[0] = 8'hC4; mem[1] = 8'h55; mem[2] = 8'hC8; mem[3] = 8'h66; mem[4] = 8'h00;
    launch(3);
    repeat (20) @(posedge clk);
    #2;
    checks++; if ({imem_req, pc} !== 9'h104) begin failures++; $display("FAIL midfetch_pre: got %h expected 104", {imem_req, pc}); end
    CLEARn = 1'b0;
    #1;
    checks++; if ({imem_req, pc, ir, zf, cf, halted} !== 20'h0) begin failures++; $display("FAIL midfetch_reset: got %h expected 0", {imem_req, pc, ir, zf, cf, halted}); end
    for (int i = 0; i < 4; i++) begin
      peek(i, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL midfetch_r%0d: got %h expected 00", i, v); end
    end
  endtask

  task automatic test_random();
    int cyc, addr, op, wn; bit ok; logic [7:0] v;
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      addr = 0;
      for (int k = 0; k < 4; k++) begin
        mem[addr] = 8'(8'hC0 + k * 4); mem[addr + 1] = 8'($urandom); addr += 2;
      end
      for (int k = 0; k < 16; k++) begin
        op = int'($urandom_range(0, 12));
        mem[addr] = 8'(op * 16 + int'($urandom_range(0, 15)));
        addr++;
        if (op == 12) begin mem[addr] = 8'($urandom); addr++; end
      end
      wn = int'($urandom_range(0, 2));
      wait_n = wn;
      model_run();
      launch(wn);
      wait_halt(cyc, ok);
      checks++; if (cyc !== m_cyc) begin failures++; $display("FAIL rand%0d_cycles: got %0d expected %0d", p, cyc, m_cyc); end
      checks++; if (pc !== 8'(m_pc)) begin failures++; $display("FAIL rand%0d_pc: got %h expected %h", p, pc, 8'(m_pc)); end
      checks++; if ({zf, cf} !== {m_zf, m_cf}) begin failures++; $display("FAIL rand%0d_flags: got %b expected %b", p, {zf, cf}, {m_zf, m_cf}); end
      for (int i = 0; i < 4; i++) begin
        peek(i, v);
        checks++; if (v !== 8'(m_r[i])) begin failures++; $display("FAIL rand%0d_r%0d: got %h expected %h", p, i, v, 8'(m_r[i])); end
      end
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_ldi_add();
    test_sub();
    test_jz();
    test_wait_states();
    test_muldiv();
    test_halt_wrap();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
